codemem_loader: RTL and testbench



---
 rtl/codemem_loader_pkg.sv | 28 ++
 rtl/codemem_loader.sv | 175 +++++++++++++++++
 tb/tb_codemem_loader.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codemem_loader_pkg.sv
// Shared constants and state encoding for the code-memory program loader.
// The StCsum state exists only when LOADER_CHECKSUM_EN is defined.
package codemem_loader_pkg;

    localparam int unsigned CODEMEM_DEPTH = 64;
    localparam int unsigned CODEMEM_AW    = 6;
    localparam int unsigned INSTR_W       = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCount = 3'd1,
        StHi    = 3'd2,
        StLo    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        StCsum  = 3'd4,
`endif
        StFin   = 3'd5
    } loader_state_e;

    // Count byte 0 and anything above the memory depth both mean a full load.
    function automatic logic [CODEMEM_AW:0] clamp_count(input logic [7:0] cnt);
        if (cnt == 8'd0 || cnt > 8'(CODEMEM_DEPTH)) begin
            return (CODEMEM_AW + 1)'(CODEMEM_DEPTH);
        end
        return cnt[CODEMEM_AW:0];
    endfunction

endpackage

// File: rtl/codemem_loader.sv
// Byte-stream program loader driving the 64 x 16 code-memory write port.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data.
module codemem_loader
    import codemem_loader_pkg::*;
#(
    parameter logic [CODEMEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  c1,
    output logic [CODEMEM_AW-1:0] write_select,
    output logic [INSTR_W-1:0]    inp,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    loader_state_e         state_q, state_d;
    logic [CODEMEM_AW:0]   words_left_q, words_left_d;
    logic [CODEMEM_AW-1:0] addr_q, addr_d;
    logic [7:0]            hi_q, hi_d;
    logic                  c1_q, c1_d;
    logic [CODEMEM_AW-1:0] wsel_q, wsel_d;
    logic [INSTR_W-1:0]    inp_q, inp_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  ready;
    logic                  accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        hi_d         = hi_q;
        c1_d         = 1'b0;
        wsel_d       = wsel_q;
        inp_d        = inp_q;
        done_d       = 1'b0;
        error_d      = error_q;
        ready        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        unique case (state_q)
            StCount, StHi, StLo: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            StCsum:              ready = 1'b1;
`endif
            default:             ready = 1'b0;
        endcase
        accept = byte_valid && ready;

        unique case (state_q)
            StIdle: begin
                // done_q still high means the previous load is not yet fully retired
                if (start && !done_q) begin
                    state_d = StCount;
                    error_d = 1'b0;
                end
            end
            StCount: begin
                if (accept) begin
                    words_left_d = clamp_count(byte_in);
                    addr_d       = BASE_ADDR;
                    state_d      = StHi;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = 8'd0;
`endif
                end
            end
            StHi: begin
                if (accept) begin
                    hi_d    = byte_in;
                    state_d = StLo;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_in;
`endif
                end
            end
            StLo: begin
                if (accept) begin
                    c1_d         = 1'b1;
                    wsel_d       = addr_q;
                    inp_d        = {hi_q, byte_in};
                    addr_d       = addr_q + 1'b1;
                    words_left_d = words_left_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = sum_q + byte_in;
                    state_d      = (words_left_q == (CODEMEM_AW + 1)'(1)) ? StCsum : StHi;
`else
                    state_d      = (words_left_q == (CODEMEM_AW + 1)'(1)) ? StFin : StHi;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    if (byte_in != sum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = StFin;
                end
            end
`endif
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including a coincident low-byte write.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            error_d = 1'b1;
            c1_d    = 1'b0;
            done_d  = 1'b0;
            wsel_d  = wsel_q;
            inp_d   = inp_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            words_left_q <= '0;
            addr_q       <= '0;
            hi_q         <= '0;
            c1_q         <= 1'b0;
            wsel_q       <= '0;
            inp_q        <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            c1_q         <= c1_d;
            wsel_q       <= wsel_d;
            inp_q        <= inp_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign byte_ready   = ready;
    assign c1           = c1_q;
    assign write_select = wsel_q;
    assign inp          = inp_q;
    // busy covers the done cycle so the CPU hold drops only after completion is signalled
    assign busy         = (state_q != StIdle) || done_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_codemem_loader.sv
// Randomized bench for codemem_loader: two instances (base 0 and base 62) share stimulus
// and are checked every cycle against a stream-level model of expected writes and handshakes.
module tb_codemem_loader;

    localparam int         BIG    = 32'h3fff_ffff;
    localparam logic [5:0] BASE_B = 6'd62;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b1;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in    = 8'h00;

    logic        ready_a, c1_a, busy_a, done_a, error_a;
    logic [5:0]  ws_a;
    logic [15:0] inp_a;
    logic        ready_b, c1_b, busy_b, done_b, error_b;
    logic [5:0]  ws_b;
    logic [15:0] inp_b;

    codemem_loader #(.BASE_ADDR(6'd0)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_a),
        .c1(c1_a), .write_select(ws_a), .inp(inp_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    codemem_loader #(.BASE_ADDR(BASE_B)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_b),
        .c1(c1_b), .write_select(ws_b), .inp(inp_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          k;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  exp_done  = -1;
    int  busy_from = BIG;
    int  busy_to   = -1;
    int  ready_to  = -1;

    logic [15:0] mem_a[64] = '{default: 16'h0000};
    logic [15:0] mem_b[64] = '{default: 16'h0000};
    logic [15:0] exp_a[64] = '{default: 16'h0000};
    logic [15:0] exp_b[64] = '{default: 16'h0000};

    // Code-memory models capture the word on the edge after the strobe cycle.
    always @(posedge clock) begin
        if (c1_a) mem_a[ws_a] <= inp_a;
        if (c1_b) mem_b[ws_b] <= inp_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clock) begin : compare
        wr_t w;
        #1;
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                w = exp_q.pop_front();
                chk("c1_a", c1_a, 1);
                chk("c1_b", c1_b, 1);
                chk("wsel_a", ws_a, w.k % 64);
                chk("wsel_b", ws_b, (62 + w.k) % 64);
                chk("inp_a", inp_a, w.data);
                chk("inp_b", inp_b, w.data);
            end else begin
                chk("c1_quiet_a", c1_a, 0);
                chk("c1_quiet_b", c1_b, 0);
            end
            chk("done_a", done_a, cyc == exp_done);
            chk("done_b", done_b, cyc == exp_done);
            chk("busy_a", busy_a, cyc >= busy_from && cyc <= busy_to);
            chk("busy_b", busy_b, cyc >= busy_from && cyc <= busy_to);
            chk("ready_a", ready_a, cyc >= busy_from && cyc <= ready_to);
        end
    end

    function automatic int clamp_n(input logic [7:0] c);
        return (c == 8'd0 || c > 8'd64) ? 64 : int'(c);
    endfunction

    function automatic logic [7:0] data_sum(input logic [7:0] s[$]);
        logic [7:0] sum = 8'd0;
        for (int j = 1; j < s.size(); j++) sum += s[j];
        return sum;
    endfunction

    task automatic make_stream(input logic [7:0] cnt, output logic [7:0] s[$]);
        int n;
        n = clamp_n(cnt);
        s = {};
        s.push_back(cnt);
        for (int j = 0; j < 2 * n; j++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        s.push_back(data_sum(s));
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", ready_a, 0);
        chk("rst_c1", c1_a, 0);
        chk("rst_wsel", ws_a, 0);
        chk("rst_inp", inp_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", error_a, 0);
    endtask

    task automatic run_load(input logic [7:0] s[$], input int abort_at, input bit gappy,
                            input bit start_mid, input int reset_at);
        int         n;
        int         last_idx;
        int         k;
        bit         tog;
        bit         acc;
        bit         stop;
        bit         exp_err;
        logic [7:0] sum;

        n        = clamp_n(s[0]);
        last_idx = 2 * n;
`ifdef LOADER_CHECKSUM_EN
        last_idx = 2 * n + 1;
`endif
        exp_err = 1'b0;
        sum     = 8'd0;
        tog     = 1'b0;
        stop    = 1'b0;

        @(negedge clock);
        start     = 1'b1;
        busy_from = cyc + 1;
        busy_to   = BIG;
        ready_to  = BIG;
        @(negedge clock);
        start = 1'b0;
        chk("error_cleared_a", error_a, 0);
        chk("error_cleared_b", error_b, 0);

        for (int i = 0; i < s.size() && !stop; i++) begin
            if (i == reset_at) begin
                byte_valid = 1'b0;
                repeat (2) @(negedge clock);
                exp_q.delete();
                exp_done  = -1;
                busy_from = BIG;
                busy_to   = -1;
                ready_to  = -1;
                reset_n   = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            acc = 1'b0;
            for (int w = 0; w < 8 && !acc; w++) begin
                tog        = ~tog;
                byte_in    = s[i];
                byte_valid = gappy ? tog : 1'b1;
                abort      = (i == abort_at) && byte_valid;
                start      = start_mid && (i == 5);
                acc        = byte_valid && ready_a;
                if (acc) begin
                    if (i >= 2 && i % 2 == 0 && i <= 2 * n && i != abort_at) begin
                        k = (i - 2) / 2;
                        exp_q.push_back('{cyc + 1, k, {s[i-1], s[i]}});
                        exp_a[k % 64]        = {s[i-1], s[i]};
                        exp_b[(62 + k) % 64] = {s[i-1], s[i]};
                    end
                    if (i == abort_at) begin
                        exp_err  = 1'b1;
                        ready_to = cyc;
                        busy_to  = cyc;
                        stop     = 1'b1;
                    end else if (i == last_idx) begin
                        ready_to = cyc;
                        busy_to  = cyc + 2;
                        exp_done = cyc + 2;
                        if (i > 2 * n && s[i] != sum) exp_err = 1'b1;
                    end
                    if (i >= 1 && i <= 2 * n) sum += s[i];
                end
                @(negedge clock);
            end
            if (!acc) begin
                chk("byte_accept_timeout", 0, 1);
                stop = 1'b1;
            end
        end
        byte_valid = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
        repeat (4) @(negedge clock);
        chk("error_a", error_a, exp_err);
        chk("error_b", error_b, exp_err);
        chk("writes_outstanding", exp_q.size(), 0);
        for (int j = 0; j < 64; j++) begin
            chk("mem_a", mem_a[j], exp_a[j]);
            chk("mem_b", mem_b[j], exp_b[j]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [7:0] s[$];
        int         cnt;
        int         n;
        int         ab;

        #2;
        reset_n = 1'b0;
        #2;
        check_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // Two-word load from the example stream.
        s = {};
        s.push_back(8'h02); s.push_back(8'h12); s.push_back(8'h34);
        s.push_back(8'hAB); s.push_back(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        s.push_back(data_sum(s));
`endif
        run_load(s, -1, 1'b0, 1'b0, -1);
        chk("pin_a0", mem_a[0], 16'h1234);
        chk("pin_a1", mem_a[1], 16'hABCD);
        chk("pin_b62", mem_b[62], 16'h1234);
        chk("pin_b63", mem_b[63], 16'hABCD);

        // Four words 0x0001..0x0004; base-62 instance wraps to 0 and 1.
        s = {};
        s.push_back(8'h04);
        for (int j = 1; j <= 4; j++) begin
            s.push_back(8'h00);
            s.push_back(8'(j));
        end
`ifdef LOADER_CHECKSUM_EN
        s.push_back(data_sum(s));
`endif
        run_load(s, -1, 1'b0, 1'b0, -1);
        chk("wrap_b62", mem_b[62], 16'h0001);
        chk("wrap_b63", mem_b[63], 16'h0002);
        chk("wrap_b0", mem_b[0], 16'h0003);
        chk("wrap_b1", mem_b[1], 16'h0004);
        chk("wrap_a3", mem_a[3], 16'h0004);

        // Count 0 and count above 64 both mean 64 words.
        make_stream(8'h00, s);
        run_load(s, -1, 1'b0, 1'b0, -1);
        make_stream(8'h50, s);
        run_load(s, -1, 1'b0, 1'b0, -1);

        // Gapped valid with an ignored start mid-load.
        make_stream(8'h05, s);
        run_load(s, -1, 1'b1, 1'b1, -1);

        // Abort on the low byte of the third of five words.
        make_stream(8'h05, s);
        run_load(s, 6, 1'b0, 1'b0, -1);
        chk("abort_error_pin", error_a, 1);

        // Reset in the middle of a load, then recover.
        make_stream(8'h06, s);
        run_load(s, -1, 1'b0, 1'b0, 5);

        for (int t = 0; t < 8; t++) begin
            cnt = $urandom_range(0, 80);
            make_stream(8'(cnt), s);
            n  = clamp_n(8'(cnt));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : -1;
            run_load(s, ab, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

`ifdef LOADER_CHECKSUM_EN
        s = {};
        s.push_back(8'h01); s.push_back(8'h10); s.push_back(8'h20); s.push_back(8'h30);
        run_load(s, -1, 1'b0, 1'b0, -1);
        chk("csum_ok_pin", error_a, 0);
        s = {};
        s.push_back(8'h01); s.push_back(8'h10); s.push_back(8'h20); s.push_back(8'h31);
        run_load(s, -1, 1'b0, 1'b0, -1);
        chk("csum_bad_pin", error_a, 1);
        chk("csum_bad_written", mem_a[0], 16'h1020);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
